// File: rtl/maxpool_sequencer.sv
// 2x2 / stride-2 max-pool controller: walks every output pixel, fetches its four
// input taps through one synchronous-read port and folds them with a single comparator.
module maxpool_sequencer #(
    parameter int  BITWIDTH = 32,
    parameter int  CHANNELS = 2,
    parameter int  IN_DIM   = 28,
    localparam int OUT_DIM  = IN_DIM / 2,
    localparam int IN_AW    = $clog2(CHANNELS * IN_DIM * IN_DIM),
    localparam int OUT_AW   = $clog2(CHANNELS * OUT_DIM * OUT_DIM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                in_rd_en,
    output logic [IN_AW-1:0]    in_rd_addr,
    input  logic [BITWIDTH-1:0] in_rd_data,
    output logic                out_wr_en,
    output logic [OUT_AW-1:0]   out_wr_addr,
    output logic [BITWIDTH-1:0] out_wr_data,
    input  logic                out_wr_ready
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OD_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [OD_W-1:0]  OD_LAST  = OD_W'(OUT_DIM - 1);
    localparam logic [IN_AW-1:0] STEP_COL = IN_AW'(2);
    // Leaving the last column skips the odd input row as well; this also carries
    // cleanly into the next channel because IN_DIM is even.
    localparam logic [IN_AW-1:0] STEP_ROW = IN_AW'(IN_DIM + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  k_q, k_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [OD_W-1:0]             orow_q, orow_d;
    logic [OD_W-1:0]             ocol_q, ocol_d;
    logic [IN_AW-1:0]            base_q, base_d;
    logic signed [BITWIDTH-1:0]  acc_q, acc_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        rd_en_q, rd_en_d;
    logic [IN_AW-1:0]            rd_addr_q, rd_addr_d;
    logic                        wr_en_q, wr_en_d;
    logic [OUT_AW-1:0]           wr_addr_q, wr_addr_d;
    logic signed [BITWIDTH-1:0]  wr_data_q, wr_data_d;

    logic signed [BITWIDTH-1:0]  rd_data_s;
    logic signed [BITWIDTH-1:0]  fold_max;
    logic                        last_pixel;

    function automatic logic [IN_AW-1:0] tap_offset(input logic [1:0] k);
        case (k)
            2'd0:    return '0;
            2'd1:    return IN_AW'(1);
            2'd2:    return IN_AW'(IN_DIM);
            default: return IN_AW'(IN_DIM + 1);
        endcase
    endfunction

    assign rd_data_s  = $signed(in_rd_data);
    assign fold_max   = (rd_data_s > acc_q) ? rd_data_s : acc_q;
    assign last_pixel = (ch_q == CH_LAST) && (orow_q == OD_LAST) && (ocol_q == OD_LAST);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        ch_d      = ch_q;
        orow_d    = orow_q;
        ocol_d    = ocol_q;
        base_d    = base_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    k_d       = 2'd0;
                    ch_d      = '0;
                    orow_d    = '0;
                    ocol_d    = '0;
                    base_d    = '0;
                    acc_d     = '0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    wr_addr_d = '0;
                end
            end
            S_FETCH: begin
                // Data visible now belongs to the tap issued one cycle earlier.
                if (k_q == 2'd1) begin
                    acc_d = rd_data_s;
                end else if (k_q != 2'd0) begin
                    acc_d = fold_max;
                end
                if (k_q == 2'd3) begin
                    state_d = S_LAST;
                    rd_en_d = 1'b0;
                end else begin
                    k_d       = k_q + 2'd1;
                    rd_addr_d = base_q + tap_offset(k_q + 2'd1);
                end
            end
            S_LAST: begin
                wr_data_d = fold_max;
                wr_en_d   = 1'b1;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                if (out_wr_ready) begin
                    wr_en_d   = 1'b0;
                    wr_addr_d = wr_addr_q + OUT_AW'(1);
                    base_d    = base_q + ((ocol_q == OD_LAST) ? STEP_ROW : STEP_COL);
                    if (ocol_q == OD_LAST) begin
                        ocol_d = '0;
                        if (orow_q == OD_LAST) begin
                            orow_d = '0;
                            ch_d   = ch_q + CH_W'(1);
                        end else begin
                            orow_d = orow_q + OD_W'(1);
                        end
                    end else begin
                        ocol_d = ocol_q + OD_W'(1);
                    end
                    if (last_pixel) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_FETCH;
                        k_d       = 2'd0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_d;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            ch_q      <= '0;
            orow_q    <= '0;
            ocol_q    <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ch_q      <= ch_d;
            orow_q    <= orow_d;
            ocol_q    <= ocol_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign in_rd_en    = rd_en_q;
    assign in_rd_addr  = rd_addr_q;
    assign out_wr_en   = wr_en_q;
    assign out_wr_addr = wr_addr_q;
    assign out_wr_data = wr_data_q;

endmodule

// File: tb/tb_maxpool_sequencer.sv
// Scoreboard bench for maxpool_sequencer: directed feature maps, expected writes queued
// before each run and popped by a monitor on every accepted write.
module tb_maxpool_sequencer;

    localparam int BW      = 32;
    localparam int CH      = 2;
    localparam int IND     = 28;
    localparam int OUTD    = IND / 2;
    localparam int IN_N    = CH * IND * IND;
    localparam int OUT_N   = CH * OUTD * OUTD;
    localparam int IN_AW   = $clog2(IN_N);
    localparam int OUT_AW  = $clog2(OUT_N);
    localparam int FULL    = OUT_N * 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              in_rd_en;
    logic [IN_AW-1:0]  in_rd_addr;
    logic [BW-1:0]     in_rd_data = '0;
    logic              out_wr_en;
    logic [OUT_AW-1:0] out_wr_addr;
    logic [BW-1:0]     out_wr_data;
    logic              out_wr_ready = 1'b1;

    maxpool_sequencer #(.BITWIDTH(BW), .CHANNELS(CH), .IN_DIM(IND)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .out_wr_ready(out_wr_ready)
    );

    always #5 clk = ~clk;

    logic signed [BW-1:0] mem [0:IN_N-1];

    always @(posedge clk) begin
        if (in_rd_en) in_rd_data <= mem[int'(in_rd_addr)];
    end

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cur_cyc = 0;
    int  wr_count, first_wr_cyc, last_wr_cyc, stall_cnt, max_rd_addr, overlap_cnt;
    int  done_seen, done_cyc;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fill_map(input int def_val, input int a0, input int v0, input int a1, input int v1);
        for (int i = 0; i < IN_N; i++) mem[i] = def_val;
        if (a0 >= 0) mem[a0] = v0;
        if (a1 >= 0) mem[a1] = v1;
    endtask

    task automatic push_expected(input int special_addr, input int special_val, input int def_val);
        wr_t e;
        exp_q.delete();
        for (int i = 0; i < OUT_N; i++) begin
            e.addr = i;
            e.data = (i == special_addr) ? special_val : def_val;
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_stats();
        wr_count = 0; first_wr_cyc = -1; last_wr_cyc = -1; stall_cnt = 0;
        max_rd_addr = 0; overlap_cnt = 0; done_seen = 0; done_cyc = -1;
    endtask

    // One launch; ready is low for cycles [1, ready_from), a stray start lands in
    // cycle restart_at, and rst_n is pulled low during cycle reset_at (-1 = never).
    task automatic run(input string tag, input int ready_from, input int restart_at, input int reset_at);
        int c;
        clear_stats();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        c = 1;
        while (c < 3000) begin
            cur_cyc = c;
            start = (c == restart_at);
            out_wr_ready = (c >= ready_from);
            rst_n = (c != reset_at);
            @(negedge clk);
            if (done) begin
                done_seen++;
                done_cyc = c;
                $display("run %s: done in cycle %0d after %0d writes", tag, c, wr_count);
            end
            if (reset_at >= 0 && c == reset_at + 1) begin
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_done"}, done, 0);
                chk({tag, "_rst_rd_en"}, in_rd_en, 0);
                chk({tag, "_rst_rd_addr"}, in_rd_addr, 0);
                chk({tag, "_rst_wr_en"}, out_wr_en, 0);
                chk({tag, "_rst_wr_addr"}, out_wr_addr, 0);
                chk({tag, "_rst_wr_data"}, out_wr_data, 0);
                exp_q.delete();
            end
            if (reset_at >= 0 && c >= reset_at + 12) break;
            if (reset_at < 0 && done_seen > 0 && c >= done_cyc + 2) break;
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        out_wr_ready = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic check_full_run(input string tag, input int extra);
        chk({tag, "_done_count"}, done_seen, 1);
        chk({tag, "_done_cycle"}, done_cyc, FULL + 1 + extra);
        chk({tag, "_last_wr_cycle"}, last_wr_cyc, FULL + extra);
        chk({tag, "_wr_count"}, wr_count, OUT_N);
        chk({tag, "_sb_left"}, exp_q.size(), 0);
        chk({tag, "_rd_wr_overlap"}, overlap_cnt, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        bit   hold_vld;
        int   hold_addr, hold_data;
        wr_t  e;
        clear_stats();
        hold_vld = 1'b0; hold_addr = 0; hold_data = 0;

        fork
            forever begin
                @(negedge clk);
                if (hold_vld) begin
                    chk("stall_wr_en", out_wr_en, 1);
                    chk("stall_addr", out_wr_addr, hold_addr);
                    chk("stall_data", $signed(out_wr_data), hold_data);
                end
                hold_vld  = out_wr_en && !out_wr_ready;
                hold_addr = int'(out_wr_addr);
                hold_data = $signed(out_wr_data);
                if (hold_vld) stall_cnt++;
                if (in_rd_en && int'(in_rd_addr) > max_rd_addr) max_rd_addr = int'(in_rd_addr);
                if (in_rd_en && out_wr_en) overlap_cnt++;
                if (out_wr_en && out_wr_ready) begin
                    wr_count++;
                    if (first_wr_cyc < 0) first_wr_cyc = cur_cyc;
                    last_wr_cyc = cur_cyc;
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_write", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", out_wr_addr, e.addr);
                        chk("wr_data", $signed(out_wr_data), e.data);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", in_rd_en, 0);
        chk("reset_rd_addr", in_rd_addr, 0);
        chk("reset_wr_en", out_wr_en, 0);
        chk("reset_wr_addr", out_wr_addr, 0);
        chk("reset_wr_data", out_wr_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Zero map with a distinct first window: max of {1,2,3,1145}.
        fill_map(0, 0, 1, 1, 2);
        mem[28] = 3; mem[29] = 1145;
        push_expected(0, 1145, 0);
        run("zero_map", 0, -1, -1);
        check_full_run("zero_map", 0);
        chk("zero_map_first_wr_cycle", first_wr_cyc, 6);

        // All -5 with one -1: signed compare must pick -1.
        fill_map(-5, 29, -1, -1, 0);
        push_expected(0, -1, -5);
        run("neg_map", 0, -1, -1);
        check_full_run("neg_map", 0);

        // Corner of channel 1 exercises the channel stride and the top read address.
        fill_map(0, IN_N - 1, 7, -1, 0);
        push_expected(OUT_N - 1, 7, 0);
        run("corner", 0, -1, -1);
        check_full_run("corner", 0);
        chk("corner_max_rd_addr", max_rd_addr, IN_N - 1);

        // Three ready-low cycles on the first write.
        push_expected(OUT_N - 1, 7, 0);
        run("stall", 9, -1, -1);
        check_full_run("stall", 3);
        chk("stall_cycles", stall_cnt, 3);
        chk("stall_first_accept", first_wr_cyc, 9);

        // A second start mid-run must be ignored.
        push_expected(OUT_N - 1, 7, 0);
        run("restart", 0, 100, -1);
        check_full_run("restart", 0);

        // Reset mid-run, then a clean full run.
        push_expected(OUT_N - 1, 7, 0);
        run("abort", 0, -1, 500);
        chk("abort_done_count", done_seen, 0);
        chk("abort_wr_en_after", out_wr_en, 0);
        fill_map(0, 0, 1, 1, 2);
        mem[28] = 3; mem[29] = 1145;
        push_expected(0, 1145, 0);
        run("after_abort", 0, -1, -1);
        check_full_run("after_abort", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_sequencer.md
# maxpool_sequencer

Sequential controller that runs 2x2/stride-2 max pooling over a multi-channel square feature map held in a single-port synchronous-read buffer, writing the pooled map into an output buffer. It replaces the fully-parallel pooling stage with one comparator path shared across all output pixels. A start/busy/done handshake lets the layer scheduler launch it, and write backpressure lets the output buffer stall it.

## Interface
- BITWIDTH, 32, element width; elements are signed two's complement
- CHANNELS, 2, number of feature-map channels
- IN_DIM, 28, input rows = columns; must be even; OUT_DIM = IN_DIM/2
- Derived localparams: IN_AW = clog2(CHANNELS*IN_DIM*IN_DIM) (11 at defaults), OUT_AW = clog2(CHANNELS*OUT_DIM*OUT_DIM) (9 at defaults)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  launch request; sampled only in IDLE
- busy  out  1  high from first read cycle through last write-accept cycle
- done  out  1  one-cycle pulse after the last write is accepted
- in_rd_en  out  1  input buffer read strobe
- in_rd_addr  out  IN_AW  read address = ch*IN_DIM*IN_DIM + row*IN_DIM + col
- in_rd_data  in  BITWIDTH  read data, valid exactly one cycle after in_rd_en
- out_wr_en  out  1  output write request, held until accepted
- out_wr_addr  out  OUT_AW  address = ch*OUT_DIM*OUT_DIM + orow*OUT_DIM + ocol
- out_wr_data  out  BITWIDTH  pooled value
- out_wr_ready  in  1  write accepted on cycles where out_wr_en && out_wr_ready

## Operation
- States: IDLE, FETCH (tap counter k = 0..3), LAST, WRITE, DONE.
- IDLE: start=1 -> FETCH with k=0 and ch/orow/ocol = 0. start=0 -> stay.
- FETCH: assert in_rd_en. Tap k address = base + {0, 1, IN_DIM, IN_DIM+1}[k], where base = ch*IN_DIM*IN_DIM + 2*orow*IN_DIM + 2*ocol. k=3 -> LAST.
- Data return: tap k data arrives in the cycle after its read. For tap 0, acc <= data. For taps 1..3, acc <= (data > acc, signed) ? data : acc. Ties keep acc.
- LAST: no read. Fold tap 3 into the result, register it into out_wr_data, then -> WRITE.
- WRITE: out_wr_en=1. out_wr_addr and out_wr_data stay stable until accepted. On accept:
  - out_wr_addr increments.
  - Counters advance: ocol fastest, then orow, then ch.
  - If that was the final pixel (ch=CHANNELS-1, orow=ocol=OUT_DIM-1) -> DONE; else -> FETCH, k=0.
- DONE: done=1 and busy=0 for one cycle, then -> IDLE.
- start while busy or in DONE: ignored, with no restart or queuing.
- rst_n=0 at any clock edge, including mid-run: immediate return to IDLE. Counters and acc clear. Outputs take reset values. A pending write is dropped and no done pulse is issued.

## Timing
- Reset values: busy=0, done=0, in_rd_en=0, in_rd_addr=0, out_wr_en=0, out_wr_addr=0, out_wr_data=0.
- Cycle 0 is the edge where start is sampled. Cycles 1-4 are FETCH, cycle 5 is LAST, cycle 6 is the first WRITE.
- Per output: 6 cycles with out_wr_ready held high; each ready-low cycle in WRITE adds 1.
- Full run at defaults with ready held high: 392 outputs x 6 = 2352 cycles. Last write occurs in cycle 2352 and done pulses in cycle 2353.
- in_rd_en is low in LAST, WRITE, DONE and IDLE. out_wr_en is high only in WRITE.

## Test plan
- Zero map at defaults; in addrs 0, 1, 28, 29 = 1, 2, 3, 1145 -> out addr 0 = 1145, out addrs 1..391 = 0. done pulses in cycle 2353 with exactly 392 writes, addresses 0..391 in order.
- All inputs = -5 except in addr 29 = -1 -> out addr 0 = -1 and all other outputs = -5, confirming signed compare.
- In addr 1567 (ch1, row 27, col 27) = 7, rest 0 -> out addr 391 = 7. This checks channel stride 784, and in_rd_addr never exceeds 1567.
- Hold out_wr_ready low for 3 cycles on the first write -> out_wr_en, addr 0 and data stay stable throughout. Accept occurs on the 4th WRITE cycle, and total runtime grows by exactly 3 cycles.
- Pulse start again in cycle 100 of a run -> no effect, and the run ends on schedule with a single done pulse.
- Assert rst_n=0 in cycle 500 -> next cycle all outputs are at reset values and no done pulse occurs. A new start then produces a full correct 392-write run.
